// File: rtl/i2s_audio_rx.sv
// i2s_audio_rx
//   I2S receiver running entirely in the system clock domain. The raw SCK,
//   WS and SD pins are oversampled through synchronisers, and the framing
//   logic steps once per detected SCK rising edge. The top A bits of each
//   word on the selected channel are kept, and one sample per frame is
//   presented to the FM modulator.
//
// Ports
//   clk             system clock, at least 4x the SCK frequency
//   rst             synchronous active-high reset
//   i2s_sck         raw I2S bit clock (asynchronous)
//   i2s_ws          raw word select, 0 = left, 1 = right (asynchronous)
//   i2s_sd          raw serial data, MSB first, two's complement (asynchronous)
//   i2s_ws_align    0: standard I2S (MSB one SCK after the WS edge),
//                   1: left-justified (MSB on the WS-edge SCK)
//   audio_chan_sel  0: output left words, 1: output right words
//   audio           last complete sample, held between updates
//   audio_valid     one-clk pulse when audio updates
//   locked          high after the first WS edge, low after reset or timeout

module i2s_audio_rx #(
  parameter int A    = 8,
  parameter int TO_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i2s_sck,
  input  logic         i2s_ws,
  input  logic         i2s_sd,
  input  logic         i2s_ws_align,
  input  logic         audio_chan_sel,
  output logic [A-1:0] audio,
  output logic         audio_valid,
  output logic         locked
);

  localparam int CW = $clog2(A + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MSB,
    SHIFT,
    DONE
  } state_e;

  logic            sckS1_q, sckS2_q, sckS3_q;
  logic            wsS1_q, wsS2_q;
  logic            sdS1_q, sdS2_q;

  logic            wsPrev_q;
  state_e          state_q;
  logic [CW-1:0]   bitCnt_q;
  logic [A-2:0]    shiftReg_q;
  logic            chan_q;
  logic            sel_q;
  logic [TO_W-1:0] toCnt_q;
  logic [TO_W-1:0] toCnt_d;
  logic [A-1:0]    audio_q;
  logic            audioValid_q;
  logic            locked_q;

  logic            sckRise;
  logic            wsEdge;
  logic            timeout;
  logic            wordStart;
  logic [A-1:0]    shiftReg_d;

  // Two-flop synchronisers on all three pins. SCK gets a third flop so a
  // rising edge can be detected from two already-synchronised samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sckS1_q <= 1'b0;
      sckS2_q <= 1'b0;
      sckS3_q <= 1'b0;
      wsS1_q  <= 1'b0;
      wsS2_q  <= 1'b0;
      sdS1_q  <= 1'b0;
      sdS2_q  <= 1'b0;
    end else begin
      sckS1_q <= i2s_sck;
      sckS2_q <= sckS1_q;
      sckS3_q <= sckS2_q;
      wsS1_q  <= i2s_ws;
      wsS2_q  <= wsS1_q;
      sdS1_q  <= i2s_sd;
      sdS2_q  <= sdS1_q;
    end
  end

  // Edge/event decode. A timed-out receiver ignores the rise that happens to
  // coincide with the saturated counter, so framing always restarts from a
  // clean IDLE. The shift candidate is built once here so the completing
  // rise can output the full word straight away.
  always_comb begin
    sckRise    = sckS2_q & ~sckS3_q;
    wsEdge     = wsS2_q ^ wsPrev_q;
    timeout    = &toCnt_q;
    wordStart  = sckRise & wsEdge & ~timeout;
    shiftReg_d = {shiftReg_q, sdS2_q};
    toCnt_d    = toCnt_q;
    if (sckRise) begin
      toCnt_d = '0;
    end else if (!timeout) begin
      toCnt_d = toCnt_q + 1'b1;
    end
  end

  // SCK inactivity counter: cleared by every SCK rise, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt_q <= '0;
    end else begin
      toCnt_q <= toCnt_d;
    end
  end

  // Framing FSM with registered outputs. The state-specific work (shifting,
  // completing a word) is done first; a WS edge on the same rise then
  // overrides the framing registers to start the next word, so a word whose
  // last bit coincides with the edge still completes and is output. Mode and
  // channel select are captured only at word start so mid-word changes only
  // affect the following word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsPrev_q     <= 1'b0;
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      shiftReg_q   <= '0;
      chan_q       <= 1'b0;
      sel_q        <= 1'b0;
      audio_q      <= '0;
      audioValid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      audioValid_q <= 1'b0;
      if (timeout) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
        wsPrev_q <= wsS2_q;
        bitCnt_q <= '0;
      end else if (sckRise) begin
        wsPrev_q <= wsS2_q;
        case (state_q)
          IDLE: begin
          end
          WAIT_MSB: begin
            shiftReg_q <= shiftReg_d[A-2:0];
            bitCnt_q   <= CW'(1);
            state_q    <= SHIFT;
          end
          SHIFT: begin
            if (bitCnt_q == CW'(A - 1)) begin
              if (chan_q == sel_q) begin
                audio_q      <= shiftReg_d;
                audioValid_q <= 1'b1;
              end
              state_q <= DONE;
            end else begin
              shiftReg_q <= shiftReg_d[A-2:0];
              bitCnt_q   <= bitCnt_q + 1'b1;
            end
          end
          DONE: begin
          end
          default: begin
            state_q <= IDLE;
          end
        endcase

        if (wordStart) begin
          locked_q <= 1'b1;
          chan_q   <= wsS2_q;
          sel_q    <= audio_chan_sel;
          if (i2s_ws_align) begin
            shiftReg_q <= shiftReg_d[A-2:0];
            bitCnt_q   <= CW'(1);
            state_q    <= SHIFT;
          end else begin
            bitCnt_q <= '0;
            state_q  <= WAIT_MSB;
          end
        end
      end
    end
  end

  assign audio       = audio_q;
  assign audio_valid = audioValid_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// tb_i2s_audio_rx
//   Directed bench for i2s_audio_rx. An I2S transmitter model serialises
//   16-bit (or shorter) left/right word pairs in either standard or
//   left-justified alignment; a monitor counts audio_valid pulses and
//   records the sample presented with each one.

module tb_i2s_audio_rx;

  localparam int A    = 8;
  localparam int HALF = 37;

  logic         clk = 1'b0;
  logic         rst;
  logic         sck;
  logic         ws;
  logic         sd;
  logic         wsAlign;
  logic         chanSel;
  logic [A-1:0] audio;
  logic         audioValid;
  logic         locked;

  int           total = 0;
  int           bad = 0;
  int           validCnt = 0;
  int           baseCnt = 0;
  int           run = 0;
  bit           longPulse = 1'b0;
  logic [A-1:0] lastAudio = '0;

  logic         wsQ[$];
  logic         sdQ[$];

  always #5 clk = ~clk;

  i2s_audio_rx #(
    .A   (A),
    .TO_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i2s_sck       (sck),
    .i2s_ws        (ws),
    .i2s_sd        (sd),
    .i2s_ws_align  (wsAlign),
    .audio_chan_sel(chanSel),
    .audio         (audio),
    .audio_valid   (audioValid),
    .locked        (locked)
  );

  // Count valid pulses away from the active edge and flag any pulse that
  // stays high for more than one clock.
  always @(negedge clk) begin
    if (audioValid === 1'b1) begin
      validCnt = validCnt + 1;
      lastAudio = audio;
      run = run + 1;
      if (run > 1) longPulse = 1'b1;
    end else begin
      run = 0;
    end
  end

  // One SCK period: WS/SD change while SCK is low, receiver samples on rise.
  task automatic applyStimulus(input logic w, input logic d);
    ws = w;
    sd = d;
    #HALF;
    sck = 1'b1;
    #HALF;
    sck = 1'b0;
  endtask

  // Queue a left/right pair as left-justified bits; n bits per word taken
  // from the top of each 16-bit value.
  task automatic queueFrame(input logic [15:0] l, input logic [15:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      wsQ.push_back(1'b0);
      sdQ.push_back(l[15-i]);
    end
    for (int i = 0; i < n; i++) begin
      wsQ.push_back(1'b1);
      sdQ.push_back(r[15-i]);
    end
  endtask

  // Drive queued bits. Standard I2S moves WS one bit earlier than the
  // left-justified layout; the bit after the queue is assumed to be left.
  task automatic driveBits(input int first, input int last, input bit std);
    logic w;
    for (int k = first; k <= last; k++) begin
      if (std) w = (k + 1 < wsQ.size()) ? wsQ[k+1] : 1'b0;
      else     w = wsQ[k];
      applyStimulus(w, sdQ[k]);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset(input logic align, input logic sel);
    rst = 1'b1;
    sck = 1'b0;
    ws = 1'b0;
    sd = 1'b0;
    wsAlign = align;
    chanSel = sel;
    wsQ.delete();
    sdQ.delete();
    waitClk(3);
    rst = 1'b0;
    waitClk(2);
    baseCnt = validCnt;
  endtask

  initial begin
    $display("[TB] start");

    doReset(1'b0, 1'b0);
    checkOutput("reset_audio", 32'(audio), 32'h0);
    checkOutput("reset_valid", 32'(audioValid), 32'h0);
    checkOutput("reset_locked", 32'(locked), 32'h0);

    $display("[TB] standard I2S, left channel");
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    driveBits(0, 95, 1'b1);
    waitClk(6);
    checkOutput("m0_left_count", 32'(validCnt - baseCnt), 32'd2);
    checkOutput("m0_left_sample", 32'(lastAudio), 32'hA5);
    checkOutput("m0_left_audio", 32'(audio), 32'hA5);
    checkOutput("m0_left_locked", 32'(locked), 32'h1);

    $display("[TB] left-justified, right channel");
    doReset(1'b1, 1'b1);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    driveBits(0, 95, 1'b0);
    waitClk(6);
    checkOutput("m1_right_count", 32'(validCnt - baseCnt), 32'd3);
    checkOutput("m1_right_sample", 32'(lastAudio), 32'h3C);
    checkOutput("m1_right_locked", 32'(locked), 32'h1);

    $display("[TB] left-justified mode fed a standard stream");
    doReset(1'b1, 1'b0);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    driveBits(0, 95, 1'b1);
    waitClk(6);
    checkOutput("m1_misalign_count", 32'(validCnt - baseCnt), 32'd2);
    checkOutput("m1_misalign_sample", 32'(audio), 32'h52);

    $display("[TB] 6-bit words");
    doReset(1'b0, 1'b0);
    for (int f = 0; f < 4; f++) queueFrame(16'hFC00, 16'h5400, 6);
    driveBits(0, 47, 1'b1);
    waitClk(6);
    checkOutput("short_count", 32'(validCnt - baseCnt), 32'd0);
    checkOutput("short_audio", 32'(audio), 32'h0);
    checkOutput("short_locked", 32'(locked), 32'h1);

    $display("[TB] SCK timeout and recovery");
    doReset(1'b0, 1'b0);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    driveBits(0, 63, 1'b1);
    waitClk(100);
    checkOutput("to_before_locked", 32'(locked), 32'h1);
    checkOutput("to_before_count", 32'(validCnt - baseCnt), 32'd1);
    waitClk(200);
    checkOutput("to_after_locked", 32'(locked), 32'h0);
    checkOutput("to_after_audio", 32'(audio), 32'hA5);
    checkOutput("to_after_count", 32'(validCnt - baseCnt), 32'd1);
    wsQ.delete();
    sdQ.delete();
    queueFrame(16'h7E11, 16'h3C5A, 16);
    queueFrame(16'h7E11, 16'h3C5A, 16);
    driveBits(0, 63, 1'b1);
    waitClk(6);
    checkOutput("to_resume_locked", 32'(locked), 32'h1);
    checkOutput("to_resume_count", 32'(validCnt - baseCnt), 32'd2);
    checkOutput("to_resume_sample", 32'(lastAudio), 32'h7E);

    $display("[TB] reset pulse mid-word");
    doReset(1'b0, 1'b0);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hB7E1, 16'h3C5A, 16);
    driveBits(0, 36, 1'b1);
    checkOutput("midrst_pre_locked", 32'(locked), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_audio", 32'(audio), 32'h0);
    checkOutput("midrst_valid", 32'(audioValid), 32'h0);
    checkOutput("midrst_locked", 32'(locked), 32'h0);
    driveBits(37, 63, 1'b1);
    waitClk(6);
    checkOutput("midrst_count", 32'(validCnt - baseCnt), 32'd0);
    checkOutput("midrst_audio_after", 32'(audio), 32'h0);
    checkOutput("midrst_relock", 32'(locked), 32'h1);

    $display("[TB] channel select change mid-word");
    doReset(1'b0, 1'b0);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    queueFrame(16'hA5C3, 16'h3C5A, 16);
    driveBits(0, 35, 1'b1);
    chanSel = 1'b1;
    driveBits(36, 47, 1'b1);
    waitClk(4);
    checkOutput("sel_mid_count", 32'(validCnt - baseCnt), 32'd1);
    checkOutput("sel_mid_sample", 32'(lastAudio), 32'hA5);
    driveBits(48, 95, 1'b1);
    waitClk(6);
    checkOutput("sel_next_count", 32'(validCnt - baseCnt), 32'd3);
    checkOutput("sel_next_sample", 32'(lastAudio), 32'h3C);

    checkOutput("valid_single_cycle", 32'(longPulse), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
